frm_pad: RTL and testbench

//  Inverse of the frame trimmer. Takes a cropped window stream (32-bit beats, 4 bytes/beat, sof/eof,
//  vld/rdy) and re-inserts border beats filled with pad_value, rebuilding full FRM_COL x FRM_ROW geometry.

---
 rtl/frm_pad_pkg.sv | 37 +++
 rtl/frm_pad_pos.sv | 55 +++++
 rtl/frm_pad.sv | 166 ++++++++++++++++
 tb/tb_frm_pad.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/frm_pad_pkg.sv
// Shared types for the frame padder: one-hot FSM encoding, latched frame config, geometry defaults.
// The optional input-framing checker in frm_pad is enabled with FRM_PAD_CHK_EN.
package frm_pad_pkg;

    localparam int FRM_COL_DEF = 640;
    localparam int FRM_ROW_DEF = 400;
    localparam int BEAT_BYTES  = 4;
    localparam int DW          = 32;

    typedef enum logic [6:0] {
        S_IDLE       = 7'b000_0001,
        S_PAD_TOP    = 7'b000_0010,
        S_PAD_LEFT   = 7'b000_0100,
        S_WIN        = 7'b000_1000,
        S_PAD_RIGHT  = 7'b001_0000,
        S_PAD_BOTTOM = 7'b010_0000,
        S_FRM_DONE   = 7'b100_0000
    } state_t;

    typedef struct packed {
        logic          byp;
        logic [8:0]    row_start;
        logic [8:0]    row_end;
        logic [9:0]    col_start;
        logic [9:0]    col_end;
        logic [DW-1:0] pad;
    } cfg_t;

    // A window that does not fit inside the frame, or is not beat aligned, is run as bypass.
    function automatic logic cfg_ok(input logic [8:0] rs, input logic [8:0] re,
                                    input logic [9:0] cs, input logic [9:0] ce,
                                    input logic [8:0] row_last, input logic [9:0] col_last);
        return (rs <= re) && (re <= row_last) && (cs <= ce) && (ce <= col_last) &&
               (cs[1:0] == 2'b00) && (ce[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/frm_pad_pos.sv
// Output-frame position tracker: byte column and line of the beat currently presented on dout.
module frm_pad_pos
    import frm_pad_pkg::*;
#(
    parameter int FRM_COL = FRM_COL_DEF,
    parameter int FRM_ROW = FRM_ROW_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       adv,
    output logic [9:0] col,
    output logic [8:0] row,
    output logic       line_end,
    output logic       frame_end
);

    localparam logic [9:0] COL_LAST = 10'(FRM_COL - BEAT_BYTES);
    localparam logic [8:0] ROW_LAST = 9'(FRM_ROW - 1);

    logic [9:0] col_q, col_d;
    logic [8:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (adv) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 9'd1;
            end else begin
                col_d = col_q + 10'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col       = col_q;
    assign row       = row_q;
    assign line_end  = (col_q == COL_LAST);
    assign frame_end = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/frm_pad.sv
// Re-inserts pad_value border beats around a cropped window stream to rebuild full frames.
// Define FRM_PAD_CHK_EN to add err_cnt/err_sticky, flagging input eof misplaced against the window.
module frm_pad
    import frm_pad_pkg::*;
#(
    parameter int FRM_COL = FRM_COL_DEF,
    parameter int FRM_ROW = FRM_ROW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [8:0]    win_row_start,
    input  logic [8:0]    win_row_end,
    input  logic [9:0]    win_col_start,
    input  logic [9:0]    win_col_end,
    input  logic [DW-1:0] pad_value,
    input  logic [DW-1:0] din,
    input  logic          sof,
    input  logic          eof,
    input  logic          din_vld,
    output logic          din_rdy,
    output logic [DW-1:0] dout,
    output logic          sof_out,
    output logic          eof_out,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic [18:0]   frm_len_out,
`ifdef FRM_PAD_CHK_EN
    output logic [7:0]    err_cnt,
    output logic          err_sticky,
`endif
    output state_t        dbg_state
);

    // Handshake: a beat moves on an edge where valid && ready; valid and data never depend on ready.
    localparam logic [9:0]  COL_LAST = 10'(FRM_COL - BEAT_BYTES);
    localparam logic [8:0]  ROW_LAST = 9'(FRM_ROW - 1);
    localparam logic [18:0] FRM_LEN  = 19'(FRM_COL * FRM_ROW);

    state_t      state_q, state_d;
    cfg_t        cfg_q, cfg_d;
    logic [18:0] byp_len_q, byp_len_d;
    logic [9:0]  col;
    logic [8:0]  row;
    logic        line_end, frame_end;
    logic        pad_st, win_st, fire;
    state_t      line_next, row_done;

    frm_pad_pos #(.FRM_COL(FRM_COL), .FRM_ROW(FRM_ROW)) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q == S_IDLE),
        .adv      (fire),
        .col      (col),
        .row      (row),
        .line_end (line_end),
        .frame_end(frame_end)
    );

    assign pad_st   = (state_q == S_PAD_TOP) || (state_q == S_PAD_LEFT) ||
                      (state_q == S_PAD_RIGHT) || (state_q == S_PAD_BOTTOM);
    assign win_st   = (state_q == S_WIN);
    assign dout_vld = pad_st || (win_st && din_vld);
    assign din_rdy  = win_st && dout_rdy;
    assign dout     = pad_st ? cfg_q.pad : (win_st ? din : '0);
    assign fire     = dout_vld && dout_rdy;
    assign sof_out  = cfg_q.byp ? (win_st && sof) : (dout_vld && (row == '0) && (col == '0));
    assign eof_out  = cfg_q.byp ? (win_st && eof) : (dout_vld && frame_end);

    assign frm_len_out = cfg_q.byp ? byp_len_q : FRM_LEN;
    assign dbg_state   = state_q;

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        byp_len_d = byp_len_q;
        line_next = (cfg_q.col_start != '0) ? S_PAD_LEFT : S_WIN;
        row_done  = line_next;
        if (row == cfg_q.row_end) begin
            row_done = (cfg_q.row_end != ROW_LAST) ? S_PAD_BOTTOM : S_FRM_DONE;
        end

        unique case (state_q)
            S_IDLE: begin
                // The sof beat is left on din and taken as the first window beat.
                if (din_vld && sof) begin
                    cfg_d.byp       = !en || !cfg_ok(win_row_start, win_row_end, win_col_start,
                                                     win_col_end, ROW_LAST, COL_LAST);
                    cfg_d.row_start = win_row_start;
                    cfg_d.row_end   = win_row_end;
                    cfg_d.col_start = win_col_start;
                    cfg_d.col_end   = win_col_end;
                    cfg_d.pad       = pad_value;
                    byp_len_d       = '0;
                    if (cfg_d.byp || (win_row_start == '0 && win_col_start == '0)) state_d = S_WIN;
                    else if (win_row_start != '0) state_d = S_PAD_TOP;
                    else state_d = S_PAD_LEFT;
                end
            end
            S_PAD_TOP: begin
                if (fire && line_end && (row == cfg_q.row_start - 9'd1)) state_d = line_next;
            end
            S_PAD_LEFT: begin
                if (fire && (col == cfg_q.col_start - 10'd4)) state_d = S_WIN;
            end
            S_WIN: begin
                if (cfg_q.byp) begin
                    if (fire) byp_len_d = byp_len_q + 19'd4;
                    if (fire && eof) state_d = S_FRM_DONE;
                end else if (fire && (col == cfg_q.col_end)) begin
                    state_d = (cfg_q.col_end != COL_LAST) ? S_PAD_RIGHT : row_done;
                end
            end
            S_PAD_RIGHT: begin
                if (fire && line_end) state_d = row_done;
            end
            S_PAD_BOTTOM: begin
                if (fire && frame_end) state_d = S_FRM_DONE;
            end
            S_FRM_DONE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            byp_len_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            byp_len_q <= byp_len_d;
        end
    end

`ifdef FRM_PAD_CHK_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_sticky_q, err_sticky_d;
    logic       err_hit;

    // eof must land exactly on the last window beat of a padded frame.
    assign err_hit = win_st && !cfg_q.byp && fire &&
                     (eof != ((row == cfg_q.row_end) && (col == cfg_q.col_end)));

    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q | err_hit;
        if (err_hit && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_frm_pad.sv
// Bench for frm_pad on a 16x4 byte frame: table of window cases, scoreboarded beats, reset corner cases.
module tb_frm_pad;
    import frm_pad_pkg::*;

    localparam int          COLS = 16;
    localparam int          ROWS = 4;
    localparam logic [31:0] PAD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [8:0]  win_row_start = '0, win_row_end = '0;
    logic [9:0]  win_col_start = '0, win_col_end = '0;
    logic [31:0] pad_value = PAD;
    logic [31:0] din = '0;
    logic        sof = 1'b0, eof = 1'b0, din_vld = 1'b0, dout_rdy = 1'b0;
    logic        din_rdy, sof_out, eof_out, dout_vld;
    logic [31:0] dout;
    logic [18:0] frm_len_out;
    state_t      dbg_state;
`ifdef FRM_PAD_CHK_EN
    logic [7:0]  err_cnt;
    logic        err_sticky;
`endif

    frm_pad #(.FRM_COL(COLS), .FRM_ROW(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .win_row_start(win_row_start), .win_row_end(win_row_end),
        .win_col_start(win_col_start), .win_col_end(win_col_end),
        .pad_value(pad_value), .din(din), .sof(sof), .eof(eof), .din_vld(din_vld),
        .din_rdy(din_rdy), .dout(dout), .sof_out(sof_out), .eof_out(eof_out),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy), .frm_len_out(frm_len_out),
`ifdef FRM_PAD_CHK_EN
        .err_cnt(err_cnt), .err_sticky(err_sticky),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        int rs, re, cs, ce;
        bit byp;       // expected: frame is passed through untouched
        int n_byp;     // input beats when bypassed
        bit rnd;       // random handshake pacing
        int exp_len;   // expected frm_len_out after the frame
    } case_t;

    case_t       cases[9];
    logic [33:0] in_q[$];
    logic [33:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        din_vld = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
        din = '0;
        dout_rdy = 1'b0;
    endtask

    task automatic set_cfg(input case_t tc);
        en            = tc.en;
        win_row_start = 9'(tc.rs);
        win_row_end   = 9'(tc.re);
        win_col_start = 10'(tc.cs);
        win_col_end   = 10'(tc.ce);
    endtask

    // Builds the input beats and the expected full-frame output; extra_eof marks one more eof on that window beat.
    task automatic build(input case_t tc, input int extra_eof);
        int nwin = 0;
        int k = 0;
        logic [31:0] d;
        in_q.delete();
        exp_q.delete();
        if (tc.byp) begin
            for (int i = 0; i < tc.n_byp; i++) begin
                d = $urandom();
                in_q.push_back({d, i == 0, i == tc.n_byp - 1});
                exp_q.push_back({d, i == 0, i == tc.n_byp - 1});
            end
        end else begin
            nwin = (tc.re - tc.rs + 1) * ((tc.ce - tc.cs) / 4 + 1);
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c += 4) begin
                    if (r >= tc.rs && r <= tc.re && c >= tc.cs && c <= tc.ce) begin
                        d = $urandom();
                        in_q.push_back({d, k == 0, (k == nwin - 1) || (k == extra_eof)});
                        k++;
                    end else begin
                        d = PAD;
                    end
                    exp_q.push_back({d, r == 0 && c == 0, r == ROWS - 1 && c == COLS - 4});
                end
            end
        end
    endtask

    // Per cycle: drive at negedge, sample #1 later, compare every accepted output beat against the queue.
    task automatic run(input int n_out, input bit rnd, input int budget);
        int got = 0;
        int idx = 0;
        int cyc = 0;
        logic [33:0] e;
        while (got < n_out && cyc < budget) begin
            @(negedge clk);
            dout_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx < in_q.size()) begin
                din_vld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                {din, sof, eof} = in_q[idx];
            end else begin
                din_vld = 1'b0;
                sof = 1'b0;
                eof = 1'b0;
            end
            #1;
            if (dout_vld && dout_rdy) begin
                e = exp_q.pop_front();
                chk($sformatf("beat%0d", got), 64'({dout, sof_out, eof_out}), 64'(e));
                got++;
            end
            if (din_vld && din_rdy) idx++;
            cyc++;
        end
        if (got < n_out) chk("timeout_beats", 64'(got), 64'(n_out));
    endtask

    task automatic post_frame(input int exp_len);
        @(negedge clk);
        drive_idle();
        #1;
        chk("done_vld", 64'(dout_vld), 64'd0);
        @(negedge clk);
        #1;
        chk("back_idle", 64'(dbg_state), 64'(S_IDLE));
        chk("frm_len", 64'(frm_len_out), 64'(exp_len));
        chk("exp_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        cases[0] = '{en:1, rs:1, re:2, cs:4, ce:8,  byp:0, n_byp:0, rnd:0, exp_len:64};
        cases[1] = '{en:1, rs:0, re:3, cs:0, ce:12, byp:0, n_byp:0, rnd:0, exp_len:64};
        cases[2] = '{en:1, rs:1, re:2, cs:4, ce:8,  byp:0, n_byp:0, rnd:1, exp_len:64};
        cases[3] = '{en:0, rs:1, re:2, cs:4, ce:8,  byp:1, n_byp:6, rnd:0, exp_len:24};
        cases[4] = '{en:1, rs:3, re:1, cs:4, ce:8,  byp:1, n_byp:5, rnd:1, exp_len:20};
        cases[5] = '{en:1, rs:0, re:0, cs:0, ce:0,  byp:0, n_byp:0, rnd:0, exp_len:64};
        cases[6] = '{en:1, rs:3, re:3, cs:12, ce:12, byp:0, n_byp:0, rnd:1, exp_len:64};
        cases[7] = '{en:1, rs:0, re:3, cs:4, ce:4,  byp:0, n_byp:0, rnd:1, exp_len:64};
        cases[8] = '{en:1, rs:0, re:1, cs:2, ce:8,  byp:1, n_byp:4, rnd:0, exp_len:16};

        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_vld", 64'(dout_vld), 64'd0);
        chk("rst_rdy", 64'(din_rdy), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_sof_eof", 64'({sof_out, eof_out}), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            set_cfg(cases[i]);
            build(cases[i], -1);
            run(exp_q.size(), cases[i].rnd, 1000);
            post_frame(cases[i].exp_len);
        end

        // Reset mid-frame after 7 output beats, then a fresh frame must start cleanly at sof_out.
        set_cfg(cases[0]);
        build(cases[0], -1);
        run(7, 1'b0, 200);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_vld", 64'(dout_vld), 64'd0);
        chk("abort_rdy", 64'(din_rdy), 64'd0);
        chk("abort_dout", 64'(dout), 64'd0);
        chk("abort_state", 64'(dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;
        build(cases[0], -1);
        run(exp_q.size(), 1'b0, 200);
        post_frame(64);

`ifdef FRM_PAD_CHK_EN
        chk("err_clean", 64'({err_sticky, err_cnt}), 64'd0);
        build(cases[0], 1);
        run(exp_q.size(), 1'b0, 200);
        post_frame(64);
        chk("err_cnt", 64'(err_cnt), 64'd1);
        chk("err_sticky", 64'(err_sticky), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
